// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding, parity types, line levels.
// Latency: n/a (package).
// Backpressure: n/a (package).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shifter for the UART transmitter: loads a byte, shifts LSB first, flags the last bit, holds the parity bit.
// Latency: load and shift take effect on the next CLK edge; ser_bit/done/par_bit are registered-state decodes.
// Backpressure: none; the owning FSM decides when to load and when to shift.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_par_typ,
  input  logic                  shift_en,
  output logic                  ser_bit,
  output logic                  done,
  output logic                  par_bit
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] shift_q;
  logic [CW-1:0]         bit_cnt;
  logic                  par_q;

  // Parity is computed once at load time so the shifter can consume the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      bit_cnt <= '0;
      par_q   <= 1'b0;
    end else if (load) begin
      shift_q <= load_data;
      bit_cnt <= '0;
      par_q   <= (^load_data) ^ (load_par_typ == PAR_ODD);
    end else if (shift_en) begin
      shift_q <= shift_q >> 1;
      bit_cnt <= done ? '0 : bit_cnt + 1'b1;
    end
  end

  // done marks that the bit currently on the line is the final payload bit.
  always_comb begin
    ser_bit = shift_q[0];
    done    = (bit_cnt == CW'(DATA_WIDTH - 1));
    par_bit = par_q;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, DATA_WIDTH bits LSB first, optional parity, stop bit; each bit PRESCALE CLKs.
// Latency: start bit drives TX_OUT the cycle after the accepting edge; frame is (DATA_WIDTH+2[+1])*PRESCALE cycles.
// Backpressure: TX_READY low while a frame is in flight (or holding slot full when UART_TX_HOLD_BUF_EN is defined); unaccepted DATA_VALID is dropped.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_READY,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  tx_state_t             state;
  tx_state_t             next_state;
  logic [PW-1:0]         pre_cnt;
  logic                  tick;
  logic                  accept;
  logic                  par_en_q;
  logic                  busy_q;

  logic                  load;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_par_en;
  logic                  load_par_typ;
  logic                  shift_en;
  logic                  ser_bit;
  logic                  ser_done;
  logic                  par_bit;

  assign tick = (pre_cnt == PW'(PRESCALE - 1));

`ifdef UART_TX_HOLD_BUF_EN
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_par_en;
  logic                  hold_par_typ;
  logic                  hold_valid;
  logic                  hold_take;
  logic                  last_stop;

  assign TX_READY  = !hold_valid;
  assign last_stop = (state == STOP) && tick;

  // Park a byte accepted mid-frame; release it when the FSM takes it at end of STOP.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_data    <= '0;
      hold_par_en  <= 1'b0;
      hold_par_typ <= 1'b0;
      hold_valid   <= 1'b0;
    end else if (accept && (state != IDLE) && !last_stop) begin
      hold_data    <= P_DATA;
      hold_par_en  <= PAR_EN;
      hold_par_typ <= PAR_TYP;
      hold_valid   <= 1'b1;
    end else if (hold_take) begin
      hold_valid   <= 1'b0;
    end
  end
`else
  assign TX_READY = (state == IDLE);
`endif

  assign accept = DATA_VALID && TX_READY;

  // State register, per-frame parity enable and registered BUSY.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      par_en_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state  <= next_state;
      busy_q <= (next_state != IDLE);
      if (load) begin
        par_en_q <= load_par_en;
      end
    end
  end

  // Bit-period counter; idle holds it at zero so every frame starts aligned.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pre_cnt <= '0;
    end else if ((state == IDLE) || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Next-state, load source selection and shift strobe.
  always_comb begin
    next_state   = state;
    load         = 1'b0;
    load_data    = P_DATA;
    load_par_en  = PAR_EN;
    load_par_typ = PAR_TYP;
    shift_en     = 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
    hold_take    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          load       = 1'b1;
          next_state = START;
        end
      end
      START: begin
        if (tick) begin
          next_state = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          if (ser_done) begin
            next_state = par_en_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          next_state = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          next_state = IDLE;
`ifdef UART_TX_HOLD_BUF_EN
          if (hold_valid) begin
            hold_take    = 1'b1;
            load         = 1'b1;
            load_data    = hold_data;
            load_par_en  = hold_par_en;
            load_par_typ = hold_par_typ;
            next_state   = START;
          end else if (accept) begin
            load       = 1'b1;
            next_state = START;
          end
`endif
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Line level is a pure decode of state so reset returns the pin high at once.
  always_comb begin
    TX_OUT = LINE_IDLE;
    case (state)
      START:   TX_OUT = LINE_START;
      DATA:    TX_OUT = ser_bit;
      PARITY:  TX_OUT = par_bit;
      STOP:    TX_OUT = LINE_STOP;
      default: TX_OUT = LINE_IDLE;
    endcase
  end

  assign BUSY = busy_q;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk          (CLK),
    .rst_n        (RST),
    .load         (load),
    .load_data    (load_data),
    .load_par_typ (load_par_typ),
    .shift_en     (shift_en),
    .ser_bit      (ser_bit),
    .done         (ser_done),
    .par_bit      (par_bit)
  );

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame at DATA_WIDTH=8, PRESCALE=8.
// Expectations track UART_TX_HOLD_BUF_EN when the bench is built with it.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_uart_tx_frame;

  localparam int PS = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_READY;
  logic       TX_OUT;
  logic       BUSY;

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  uart_tx_frame #(
    .DATA_WIDTH (8),
    .PRESCALE   (PS)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_READY   (TX_READY),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called right after a falling edge; presents a byte and lets one rising edge accept it.
  task automatic send(input logic [7:0] d, input logic pen, input logic ptyp);
    chk("ready_before_send", TX_READY, 1'b1);
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    DATA_VALID = 1'b1;
    @(posedge CLK);
    #1 DATA_VALID = 1'b0;
  endtask

  // Checks every cycle of one frame; exp_par is the hand-computed parity bit.
  task automatic check_frame(input logic [7:0] d, input logic pen, input logic exp_par,
                             input int inject_at, input logic [7:0] inj,
                             input int upd_at, input logic [7:0] upd, input bit scramble);
    int   nbits;
    int   cyc;
    logic exp_bit;
    nbits = pen ? 11 : 10;
    cyc   = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < PS; c++) begin
        @(negedge CLK);
        if (b == 0)                exp_bit = 1'b0;
        else if (b <= 8)           exp_bit = d[b-1];
        else if (pen && (b == 9))  exp_bit = exp_par;
        else                       exp_bit = 1'b1;
        chk($sformatf("tx_out_%02h_bit%0d_cyc%0d", d, b, c), TX_OUT, exp_bit);
        chk($sformatf("busy_%02h_bit%0d_cyc%0d", d, b, c), BUSY, 1'b1);
        if ((inject_at >= 0) && (cyc == inject_at + 1)) DATA_VALID = 1'b0;
        if (cyc == inject_at) begin
          DATA_VALID = 1'b1;
          P_DATA     = inj;
        end
        if (cyc == upd_at) P_DATA = upd;
        if (scramble) begin
          P_DATA  = 8'($urandom);
          PAR_EN  = 1'($urandom);
          PAR_TYP = 1'($urandom);
        end
        cyc++;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge CLK);
    chk({tag, "_tx_out"}, TX_OUT, 1'b1);
    chk({tag, "_busy"}, BUSY, 1'b0);
    chk({tag, "_ready"}, TX_READY, 1'b1);
  endtask

  initial begin
    logic [7:0] d;
    RST        = 1'b0;
    P_DATA     = 8'h00;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;

    // Reset state.
    #12;
    chk("reset_tx_out", TX_OUT, 1'b1);
    chk("reset_busy", BUSY, 1'b0);
    chk("reset_ready", TX_READY, 1'b1);
    @(negedge CLK);
    RST = 1'b1;
    check_idle("post_reset");

    // 0xA5 no parity: 0, 1,0,1,0,0,1,0,1, 1 for 80 cycles, then idle.
    send(8'hA5, 1'b0, 1'b0);
    check_frame(8'hA5, 1'b0, 1'b0, -1, 8'h00, -1, 8'h00, 1'b0);
    check_idle("a5_nopar_end");

    // 0xA5 even parity -> parity bit 0; 88 cycles.
    send(8'hA5, 1'b1, 1'b0);
    check_frame(8'hA5, 1'b1, 1'b0, -1, 8'h00, -1, 8'h00, 1'b0);
    check_idle("a5_even_end");

    // 0x03 odd parity -> parity bit 1; 88 cycles.
    send(8'h03, 1'b1, 1'b1);
    check_frame(8'h03, 1'b1, 1'b1, -1, 8'h00, -1, 8'h00, 1'b0);
    check_idle("03_odd_end");

    // 0x3C offered at cycle 20 of a 0x81 frame.
    send(8'h81, 1'b0, 1'b0);
    check_frame(8'h81, 1'b0, 1'b0, 20, 8'h3C, -1, 8'h00, 1'b0);
`ifdef UART_TX_HOLD_BUF_EN
    check_frame(8'h3C, 1'b0, 1'b0, -1, 8'h00, -1, 8'h00, 1'b0);
    check_idle("hold_3c_end");
`else
    for (int i = 0; i < 10; i++) check_idle($sformatf("drop_3c_idle%0d", i));
`endif

    // Reset during the data bits, then a clean 0x55 frame.
    send(8'hA5, 1'b0, 1'b0);
    repeat (30) @(negedge CLK);
    chk("pre_abort_busy", BUSY, 1'b1);
    #2 RST = 1'b0;
    #1;
    chk("abort_tx_out", TX_OUT, 1'b1);
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_ready", TX_READY, 1'b1);
    @(negedge CLK);
    RST = 1'b1;
    check_idle("abort_release");
    send(8'h55, 1'b0, 1'b0);
    check_frame(8'h55, 1'b0, 1'b0, -1, 8'h00, -1, 8'h00, 1'b0);
    check_idle("55_end");

    // 0xF0 odd parity (bit 1) while P_DATA/PAR_EN/PAR_TYP churn every cycle.
    send(8'hF0, 1'b1, 1'b1);
    check_frame(8'hF0, 1'b1, 1'b1, -1, 8'h00, -1, 8'h00, 1'b1);
    P_DATA  = 8'h00;
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
    check_idle("f0_end");

    // DATA_VALID held high with incrementing data.
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    P_DATA     = 8'h10;
    chk("stream_ready", TX_READY, 1'b1);
    DATA_VALID = 1'b1;
    @(posedge CLK);
`ifdef UART_TX_HOLD_BUF_EN
    #1 P_DATA = 8'h11;
`endif
    for (int f = 0; f < 3; f++) begin
      d = 8'h10 + 8'(f);
`ifdef UART_TX_HOLD_BUF_EN
      check_frame(d, 1'b0, 1'b0, -1, 8'h00, 1, d + 8'd2, 1'b0);
`else
      check_frame(d, 1'b0, 1'b0, -1, 8'h00, 1, d + 8'd1, 1'b0);
      check_idle($sformatf("stream_gap%0d", f));
`endif
    end
    DATA_VALID = 1'b0;
    repeat (200) @(negedge CLK);
    check_idle("stream_drained");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
